// File: rtl/ptol_if.sv
// Request/acknowledge bundle between a pulse-to-level converter and its consumer.
// The master drives events and acknowledges, and the slave drives the request level and status.
interface ptol_if #(
    parameter int CNT_W = 4
) ();
    logic             sig_i;
    logic             ack_i;
    logic             sig_o;
    logic [CNT_W-1:0] pend_o;
    logic             ovf_o;
    logic             tmo_o;

    modport master (
        output sig_i,
        output ack_i,
        input  sig_o,
        input  pend_o,
        input  ovf_o,
        input  tmo_o
    );

    modport slave (
        input  sig_i,
        input  ack_i,
        output sig_o,
        output pend_o,
        output ovf_o,
        output tmo_o
    );
endinterface

// File: rtl/ptol.sv
// ptol: turns event pulses into acknowledged level requests, queueing events that arrive while busy.
// Define PTOL_TIMEOUT_EN to release an unacknowledged request after TIMEOUT cycles.
module ptol #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic  clk,
    input  logic  resetn,
    ptol_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("ptol: TIMEOUT out of range");
    end

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_nx;
    logic             sig_q;
    logic             ovf_q;
    logic             ovf_nx;
    logic             inc;
    logic             dec;
    logic             tmo_hit;
    logic             release_req;

`ifdef PTOL_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_q;

    // The counter sits at zero outside HOLD, so every HOLD entry starts a fresh count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= 16'd0;
            tmo_q   <= 1'b0;
        end else begin
            if (state == HOLD) tmo_cnt <= tmo_cnt + 16'd1;
            else               tmo_cnt <= 16'd0;
            tmo_q <= tmo_hit && !bus.ack_i;
        end
    end

    assign tmo_hit   = (state == HOLD) && (tmo_cnt == TMO_LAST);
    assign bus.tmo_o = tmo_q;
`else
    assign tmo_hit   = 1'b0;
    assign bus.tmo_o = 1'b0;
`endif

    assign release_req = bus.ack_i || tmo_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            sig_q  <= 1'b0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            sig_q  <= (state_nx == HOLD);
            pend_q <= pend_nx;
            ovf_q  <= ovf_nx;
        end
    end

    // Leaving HOLD looks at the pending count including this cycle's event, so a same-cycle event re-issues.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.sig_i) state_nx = HOLD;
            HOLD:    if (release_req) state_nx = (pend_nx != '0) ? GAP : IDLE;
            GAP:     state_nx = HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // An event in IDLE becomes the request itself, so only HOLD and GAP events enter the queue.
    always_comb begin
        inc     = bus.sig_i && (state != IDLE);
        dec     = (state == GAP) && (pend_q != '0);
        pend_nx = pend_q;
        ovf_nx  = 1'b0;
        if (inc && !dec) begin
            if (pend_q == PEND_MAX) ovf_nx  = 1'b1;
            else                    pend_nx = pend_q + CNT_W'(1);
        end else if (dec && !inc) begin
            pend_nx = pend_q - CNT_W'(1);
        end
    end

    assign bus.sig_o  = sig_q;
    assign bus.pend_o = pend_q;
    assign bus.ovf_o  = ovf_q;
endmodule

// File: tb/tb_ptol.sv
// Self-checking bench for ptol: per-scenario tasks feed a scoreboard queue of expected outputs.
// The timeout scenario follows whether PTOL_TIMEOUT_EN is defined.
module tb_ptol;
    localparam int CW = 2;

    typedef struct packed {
        logic          sig;
        logic [CW-1:0] pend;
        logic          ovf;
        logic          tmo;
    } exp_t;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    ptol_if #(.CNT_W(CW)) bus ();

    ptol #(.CNT_W(CW), .TIMEOUT(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row encoding: [5]=sig_i [4]=ack_i [3]=expected sig_o [2:1]=expected pend_o [0]=expected ovf_o.
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== 5'b0)
            $display("[TB] FAIL reset_hold: got %b want 00000", {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o});
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== 5'b0)
            $display("[TB] FAIL reset_release: got %b want 00000", {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o});
        else n_pass++;
    endtask

    task automatic test_single();
        logic [5:0] rows [7] = '{6'b01_0_00_0, 6'b10_1_00_0, 6'b00_1_00_0, 6'b00_1_00_0,
                                 6'b00_1_00_0, 6'b01_0_00_0, 6'b00_0_00_0};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            bus.sig_i = rows[i][5];
            bus.ack_i = rows[i][4];
            sb.push_back({rows[i][3:0], 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== e)
                $display("[TB] FAIL single row %0d: got %b want %b", i, {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o}, e);
            else n_pass++;
        end
    endtask

    task automatic test_multi();
        logic [5:0] rows [12] = '{6'b10_1_00_0, 6'b10_1_01_0, 6'b10_1_10_0, 6'b10_1_11_0,
                                  6'b01_0_11_0, 6'b00_1_10_0, 6'b01_0_10_0, 6'b00_1_01_0,
                                  6'b01_0_01_0, 6'b00_1_00_0, 6'b01_0_00_0, 6'b00_0_00_0};
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            bus.sig_i = rows[i][5];
            bus.ack_i = rows[i][4];
            sb.push_back({rows[i][3:0], 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== e)
                $display("[TB] FAIL multi row %0d: got %b want %b", i, {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o}, e);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        logic [5:0] rows [14] = '{6'b10_1_00_0, 6'b10_1_01_0, 6'b10_1_10_0, 6'b10_1_11_0,
                                  6'b10_1_11_1, 6'b10_1_11_1, 6'b00_1_11_0, 6'b01_0_11_0,
                                  6'b00_1_10_0, 6'b01_0_10_0, 6'b00_1_01_0, 6'b01_0_01_0,
                                  6'b00_1_00_0, 6'b01_0_00_0};
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            bus.sig_i = rows[i][5];
            bus.ack_i = rows[i][4];
            sb.push_back({rows[i][3:0], 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== e)
                $display("[TB] FAIL saturate row %0d: got %b want %b", i, {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o}, e);
            else n_pass++;
        end
    endtask

    task automatic test_same_cycle();
        logic [5:0] rows [5] = '{6'b10_1_00_0, 6'b11_0_01_0, 6'b00_1_00_0, 6'b01_0_00_0, 6'b00_0_00_0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            bus.sig_i = rows[i][5];
            bus.ack_i = rows[i][4];
            sb.push_back({rows[i][3:0], 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== e)
                $display("[TB] FAIL same_cycle row %0d: got %b want %b", i, {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o}, e);
            else n_pass++;
        end
    endtask

    // An event (and an ignored ack) arriving in GAP nets out against the re-issue decrement.
    task automatic test_gap_event();
        logic [5:0] rows [6] = '{6'b10_1_00_0, 6'b11_0_01_0, 6'b11_1_01_0,
                                 6'b01_0_01_0, 6'b00_1_00_0, 6'b01_0_00_0};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            bus.sig_i = rows[i][5];
            bus.ack_i = rows[i][4];
            sb.push_back({rows[i][3:0], 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== e)
                $display("[TB] FAIL gap_event row %0d: got %b want %b", i, {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o}, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] rows [3] = '{6'b10_1_00_0, 6'b10_1_01_0, 6'b10_1_10_0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            bus.sig_i = rows[i][5];
            bus.ack_i = rows[i][4];
            sb.push_back({rows[i][3:0], 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== e)
                $display("[TB] FAIL reset_mid row %0d: got %b want %b", i, {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o}, e);
            else n_pass++;
        end
        bus.sig_i = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== 5'b0)
            $display("[TB] FAIL reset_mid_async: got %b want 00000", {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o});
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== 5'b0)
            $display("[TB] FAIL reset_mid_after: got %b want 00000", {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o});
        else n_pass++;
        test_single();
    endtask

    task automatic test_timeout();
        exp_t e;
`ifdef PTOL_TIMEOUT_EN
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 19; i++) begin
                bus.sig_i = (i == 0);
                bus.ack_i = (pass == 1) && (i == 16);
                sb.push_back({(i <= 15), 2'b00, 1'b0, (pass == 0) && (i == 16)});
                @(posedge clk);
                #1;
                e = sb.pop_front();
                n_checks++;
                if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== e)
                    $display("[TB] FAIL timeout pass %0d cycle %0d: got %b want %b", pass, i, {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o}, e);
                else n_pass++;
            end
        end
`else
        for (int i = 0; i < 40; i++) begin
            bus.sig_i = (i == 0);
            bus.ack_i = (i == 35);
            sb.push_back({(i < 35), 2'b00, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o} !== e)
                $display("[TB] FAIL no_timeout cycle %0d: got %b want %b", i, {bus.sig_o, bus.pend_o, bus.ovf_o, bus.tmo_o}, e);
            else n_pass++;
        end
`endif
        bus.ack_i = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        resetn    = 1'b0;
        bus.sig_i = 1'b0;
        bus.ack_i = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_saturate();
        test_same_cycle();
        test_gap_event();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
